// File: rtl/ncpu32k_lsu_pkg.sv
// Shared widths, access-size encodings, FSM state type and alignment helpers
// for the ncpu32k load/store unit.
package ncpu32k_lsu_pkg;

  localparam int NCPU_AW = 32;
  localparam int NCPU_DW = 32;

  localparam logic [2:0] NCPU_LSU_SIZE_B = 3'd1;
  localparam logic [2:0] NCPU_LSU_SIZE_H = 3'd2;
  localparam logic [2:0] NCPU_LSU_SIZE_W = 3'd3;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_WAIT = 2'd2,
    ST_RESP = 2'd3
  } lsu_state_e;

  // Low address bits that must be zero for a naturally aligned access.
  // Unknown size codes behave as words.
  function automatic logic [1:0] align_mask(input logic [2:0] size);
    case (size)
      NCPU_LSU_SIZE_B: align_mask = 2'b00;
      NCPU_LSU_SIZE_H: align_mask = 2'b01;
      NCPU_LSU_SIZE_W: align_mask = 2'b11;
      default:         align_mask = 2'b11;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] size, input logic [1:0] addr_lo);
    return |(addr_lo & align_mask(size));
  endfunction

endpackage

// File: rtl/ncpu32k_lsu_if.sv
// dbus link between the LSU (master) and the D-MMU (slave): command channel,
// response channel and the MMU exception flags that accompany a response.
interface ncpu32k_lsu_if;
  import ncpu32k_lsu_pkg::*;

  logic               cmd_valid;
  logic               cmd_ready;
  logic [NCPU_AW-1:0] cmd_addr;
  logic [2:0]         cmd_size;
  logic               cmd_we;
  logic [NCPU_DW-1:0] din;
  logic               valid;
  logic               ready;
  logic [NCPU_DW-1:0] dout;
  logic               exp_tlb_miss;
  logic               exp_page_fault;

  modport master (
    output cmd_valid, cmd_addr, cmd_size, cmd_we, din, ready,
    input  cmd_ready, valid, dout, exp_tlb_miss, exp_page_fault
  );

  modport slave (
    input  cmd_valid, cmd_addr, cmd_size, cmd_we, din, ready,
    output cmd_ready, valid, dout, exp_tlb_miss, exp_page_fault
  );

endinterface

// File: rtl/ncpu32k_lsu_align.sv
// Combinational lane handling: store-data replication onto all byte lanes and
// little-endian load extraction with zero/sign extension.
module ncpu32k_lsu_align
  import ncpu32k_lsu_pkg::*;
(
  input  logic [2:0]         size_i,
  input  logic               sign_ext_i,
  input  logic [1:0]         addr_lo_i,
  input  logic [NCPU_DW-1:0] wdat_i,
  input  logic [NCPU_DW-1:0] rdat_i,
  output logic [NCPU_DW-1:0] din_o,
  output logic [NCPU_DW-1:0] dout_o
);

  logic [7:0]  byte_lane;
  logic [15:0] half_lane;

  always_comb begin
    case (addr_lo_i)
      2'd0:    byte_lane = rdat_i[7:0];
      2'd1:    byte_lane = rdat_i[15:8];
      2'd2:    byte_lane = rdat_i[23:16];
      default: byte_lane = rdat_i[31:24];
    endcase
    half_lane = addr_lo_i[1] ? rdat_i[31:16] : rdat_i[15:0];

    case (size_i)
      NCPU_LSU_SIZE_B: begin
        din_o  = {4{wdat_i[7:0]}};
        dout_o = {{24{sign_ext_i & byte_lane[7]}}, byte_lane};
      end
      NCPU_LSU_SIZE_H: begin
        din_o  = {2{wdat_i[15:0]}};
        dout_o = {{16{sign_ext_i & half_lane[15]}}, half_lane};
      end
      default: begin
        din_o  = wdat_i;
        dout_o = rdat_i;
      end
    endcase
  end

endmodule

// File: rtl/ncpu32k_lsu.sv
// ncpu32k_lsu: single-outstanding load/store unit in front of the D-MMU.
// Define NCPU_LSU_MISALIGN_EXP_EN to trap misaligned half/word ops instead of truncating the address.
//  state | meaning
//  IDLE  | ready to accept an op from execute
//  CMD   | dbus command presented, waiting for cmd_ready
//  WAIT  | waiting for load data / store ack or an MMU exception
//  RESP  | result or exception held until writeback takes it
module ncpu32k_lsu
  import ncpu32k_lsu_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               lsu_in_valid_i,
  output logic               lsu_in_ready_o,
  input  logic               lsu_we_i,
  input  logic               lsu_sign_ext_i,
  input  logic [2:0]         lsu_size_i,
  input  logic [NCPU_AW-1:0] lsu_addr_i,
  input  logic [NCPU_DW-1:0] lsu_wdat_i,
  output logic               lsu_out_valid_o,
  input  logic               lsu_out_ready_i,
  output logic [NCPU_DW-1:0] lsu_dout_o,
  output logic               lsu_exp_tlb_miss_o,
  output logic               lsu_exp_page_fault_o,
  output logic               lsu_exp_misalign_o,
  output logic [NCPU_AW-1:0] lsu_exp_vaddr_o,
  ncpu32k_lsu_if.master      dbus
);

  lsu_state_e         state_q;
  logic               in_ready_q, cmd_valid_q, dbus_ready_q, out_valid_q;
  logic               we_q, sign_q;
  logic [2:0]         size_q;
  logic [NCPU_AW-1:0] addr_q;
  logic [NCPU_DW-1:0] wdat_q, dout_q;
  logic               tlb_q, pf_q, mis_q;
  logic               mis_in;
  logic [NCPU_DW-1:0] din_w, load_d;

  ncpu32k_lsu_align u_align (
    .size_i     (size_q),
    .sign_ext_i (sign_q),
    .addr_lo_i  (addr_q[1:0]),
    .wdat_i     (wdat_q),
    .rdat_i     (dbus.dout),
    .din_o      (din_w),
    .dout_o     (load_d)
  );

`ifdef NCPU_LSU_MISALIGN_EXP_EN
  assign mis_in        = is_misaligned(lsu_size_i, lsu_addr_i[1:0]);
  assign dbus.cmd_addr = addr_q;
`else
  // Without the trap, low address bits are silently dropped to the access size.
  assign mis_in        = 1'b0;
  assign dbus.cmd_addr = {addr_q[NCPU_AW-1:2], addr_q[1:0] & ~align_mask(size_q)};
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      in_ready_q   <= 1'b1;
      cmd_valid_q  <= 1'b0;
      dbus_ready_q <= 1'b0;
      out_valid_q  <= 1'b0;
      we_q         <= 1'b0;
      sign_q       <= 1'b0;
      size_q       <= '0;
      addr_q       <= '0;
      wdat_q       <= '0;
      dout_q       <= '0;
      tlb_q        <= 1'b0;
      pf_q         <= 1'b0;
      mis_q        <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: if (lsu_in_valid_i) begin
          we_q       <= lsu_we_i;
          sign_q     <= lsu_sign_ext_i;
          size_q     <= lsu_size_i;
          addr_q     <= lsu_addr_i;
          wdat_q     <= lsu_wdat_i;
          in_ready_q <= 1'b0;
          if (mis_in) begin
            mis_q       <= 1'b1;
            out_valid_q <= 1'b1;
            state_q     <= ST_RESP;
          end else begin
            cmd_valid_q <= 1'b1;
            state_q     <= ST_CMD;
          end
        end
        ST_CMD: if (dbus.cmd_ready) begin
          cmd_valid_q  <= 1'b0;
          dbus_ready_q <= 1'b1;
          state_q      <= ST_WAIT;
        end
        // An MMU exception takes priority over data arriving in the same cycle.
        ST_WAIT: if (dbus.exp_tlb_miss || dbus.exp_page_fault) begin
          tlb_q        <= dbus.exp_tlb_miss;
          pf_q         <= dbus.exp_page_fault;
          dout_q       <= '0;
          dbus_ready_q <= 1'b0;
          out_valid_q  <= 1'b1;
          state_q      <= ST_RESP;
        end else if (dbus.valid) begin
          dout_q       <= we_q ? '0 : load_d;
          dbus_ready_q <= 1'b0;
          out_valid_q  <= 1'b1;
          state_q      <= ST_RESP;
        end
        ST_RESP: if (lsu_out_ready_i) begin
          out_valid_q <= 1'b0;
          in_ready_q  <= 1'b1;
          dout_q      <= '0;
          tlb_q       <= 1'b0;
          pf_q        <= 1'b0;
          mis_q       <= 1'b0;
          state_q     <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign lsu_in_ready_o       = in_ready_q;
  assign lsu_out_valid_o      = out_valid_q;
  assign lsu_dout_o           = dout_q;
  assign lsu_exp_tlb_miss_o   = tlb_q;
  assign lsu_exp_page_fault_o = pf_q;
  assign lsu_exp_misalign_o   = mis_q;
  assign lsu_exp_vaddr_o      = addr_q;

  assign dbus.cmd_valid = cmd_valid_q;
  assign dbus.cmd_size  = size_q;
  assign dbus.cmd_we    = we_q;
  assign dbus.din       = din_w;
  assign dbus.ready     = dbus_ready_q;

endmodule

// File: tb/tb_ncpu32k_lsu.sv
// Bench for ncpu32k_lsu: directed vector table, hand-written reset/misalign sequences,
// and randomized ops checked against an arithmetic reference model.
module tb_ncpu32k_lsu;
  import ncpu32k_lsu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, we, sext, out_valid, out_ready;
  logic [2:0]  size;
  logic [31:0] addr, wdat, dout, vaddr;
  logic        tlb_o, pf_o, mis_o;

  ncpu32k_lsu_if dbus_if ();

  ncpu32k_lsu dut (
    .clk                  (clk),
    .rst                  (rst),
    .lsu_in_valid_i       (in_valid),
    .lsu_in_ready_o       (in_ready),
    .lsu_we_i             (we),
    .lsu_sign_ext_i       (sext),
    .lsu_size_i           (size),
    .lsu_addr_i           (addr),
    .lsu_wdat_i           (wdat),
    .lsu_out_valid_o      (out_valid),
    .lsu_out_ready_i      (out_ready),
    .lsu_dout_o           (dout),
    .lsu_exp_tlb_miss_o   (tlb_o),
    .lsu_exp_page_fault_o (pf_o),
    .lsu_exp_misalign_o   (mis_o),
    .lsu_exp_vaddr_o      (vaddr),
    .dbus                 (dbus_if)
  );

  int n_pass = 0;
  int n_total = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_total++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, req);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    bit          cmd;
    logic [31:0] cmd_addr, din, dout;
    bit          tlb, pf, mis;
    int          lat;
  } exp_t;

  typedef struct {
    bit          saw_cmd, cmd_stable, no_spur, wait_rdy, got_out, held;
    logic [31:0] cmd_addr, din, dout, vaddr;
    logic [2:0]  cmd_size;
    logic        cmd_we, tlb, pf, mis;
    int          lat;
  } obs_t;

  typedef struct {
    bit          we, sext;
    logic [2:0]  size;
    logic [31:0] addr, wdat, rdat;
    bit          tlb, pf, rv;
    int          cw, rw, ow;
    bit          noise;
    logic [31:0] e_cmd_addr, e_din, e_dout;
    bit          e_tlb, e_pf;
  } vec_t;

  // Reference: an access of nb bytes lives at byte offset (addr mod nb) rounding, little-endian.
  function automatic exp_t model(input bit mwe, input bit msx, input logic [2:0] msz,
                                 input logic [31:0] ma, input logic [31:0] mwd,
                                 input logic [31:0] mrd, input bit mtlb, input bit mpf,
                                 input int mcw, input int mrw);
    exp_t e;
    logic [31:0] nb, off, val, mask, sh;
    nb  = (msz == 3'd1) ? 32'd1 : (msz == 3'd2) ? 32'd2 : 32'd4;
    off = ma % nb;
    e.cmd = 1'b1; e.mis = 1'b0; e.tlb = mtlb; e.pf = mpf; e.lat = 3 + mcw + mrw;
    e.cmd_addr = ma - off;
`ifdef NCPU_LSU_MISALIGN_EXP_EN
    e.cmd_addr = ma;
    if (off != 0) begin
      e.cmd = 1'b0; e.mis = 1'b1; e.tlb = 1'b0; e.pf = 1'b0; e.lat = 1;
      e.dout = 32'd0; e.din = 32'd0;
      return e;
    end
`endif
    if (nb == 1)      e.din = {24'd0, mwd[7:0]} * 32'h0101_0101;
    else if (nb == 2) e.din = {16'd0, mwd[15:0]} * 32'h0001_0001;
    else              e.din = mwd;
    if (nb == 4) val = mrd;
    else begin
      mask = (32'd1 << (8 * nb)) - 32'd1;
      sh   = (nb == 1) ? (ma % 4) : ((ma % 4) / 2) * 2;
      val  = (mrd >> (8 * sh)) & mask;
      if (msx && val[8*nb-1]) val = val | ~mask;
    end
    e.dout = (mwe || mtlb || mpf) ? 32'd0 : val;
    return e;
  endfunction

  task automatic do_op(input bit iwe, input bit isx, input logic [2:0] isz,
                       input logic [31:0] ia, input logic [31:0] iwd, input logic [31:0] ird,
                       input bit itlb, input bit ipf, input bit irv,
                       input int cw, input int rw, input int ow, input bit noise,
                       output obs_t o);
    o.saw_cmd = 0; o.cmd_stable = 1; o.no_spur = 1; o.wait_rdy = 0; o.got_out = 0; o.held = 1;
    o.cmd_addr = '0; o.din = '0; o.dout = '0; o.vaddr = '0; o.cmd_size = '0; o.cmd_we = 0;
    o.tlb = 0; o.pf = 0; o.mis = 0; o.lat = 0;
    for (int k = 0; k < 20 && !in_ready; k++) step();
    in_valid = 1; we = iwe; sext = isx; size = isz; addr = ia; wdat = iwd;
    step();
    in_valid = 0; we = 0; sext = 0; size = 3'($urandom_range(0, 7)); addr = $urandom; wdat = $urandom;
    o.lat = 1;
    o.saw_cmd = dbus_if.cmd_valid;
    if (o.saw_cmd) begin
      o.cmd_addr = dbus_if.cmd_addr; o.cmd_size = dbus_if.cmd_size;
      o.cmd_we = dbus_if.cmd_we; o.din = dbus_if.din;
      for (int k = 0; k < cw; k++) begin
        if (noise) begin
          dbus_if.exp_tlb_miss = 1; dbus_if.exp_page_fault = 1; dbus_if.valid = 1;
        end
        step(); o.lat++;
        if (dbus_if.cmd_valid !== 1'b1 || dbus_if.cmd_addr !== o.cmd_addr ||
            dbus_if.cmd_size !== o.cmd_size || dbus_if.cmd_we !== o.cmd_we ||
            dbus_if.din !== o.din) o.cmd_stable = 0;
        if (in_ready) o.no_spur = 0;
      end
      dbus_if.exp_tlb_miss = 0; dbus_if.exp_page_fault = 0; dbus_if.valid = 0;
      dbus_if.cmd_ready = 1;
      step(); o.lat++;
      dbus_if.cmd_ready = 0;
      for (int k = 0; k < rw; k++) begin step(); o.lat++; end
      o.wait_rdy = dbus_if.ready;
      dbus_if.valid = irv; dbus_if.dout = ird;
      dbus_if.exp_tlb_miss = itlb; dbus_if.exp_page_fault = ipf;
      step(); o.lat++;
      dbus_if.valid = 0; dbus_if.exp_tlb_miss = 0; dbus_if.exp_page_fault = 0;
      dbus_if.dout = $urandom;
    end
    for (int k = 0; k < 20 && !out_valid; k++) begin
      if (in_ready) o.no_spur = 0;
      step(); o.lat++;
    end
    o.got_out = out_valid;
    o.dout = dout; o.tlb = tlb_o; o.pf = pf_o; o.mis = mis_o; o.vaddr = vaddr;
    for (int k = 0; k < ow; k++) begin
      step();
      if (out_valid !== 1'b1 || dout !== o.dout || tlb_o !== o.tlb || pf_o !== o.pf ||
          mis_o !== o.mis || vaddr !== o.vaddr) o.held = 0;
      if (in_ready) o.no_spur = 0;
    end
    out_ready = 1;
    step();
    out_ready = 0;
    if (!o.got_out) begin
      rst = 1; step(); rst = 0;
    end
  endtask

  task automatic compare(input string tag, input exp_t e, input obs_t o,
                         input bit iwe, input logic [2:0] isz, input logic [31:0] ia);
    chk({tag, ".out_valid_seen"}, 32'(o.got_out), 32'd1);
    chk({tag, ".latency"}, 32'(o.lat), 32'(e.lat));
    chk({tag, ".cmd_issued"}, 32'(o.saw_cmd), 32'(e.cmd));
    if (e.cmd && o.saw_cmd) begin
      chk({tag, ".cmd_addr"}, o.cmd_addr, e.cmd_addr);
      chk({tag, ".cmd_we"}, 32'(o.cmd_we), 32'(iwe));
      chk({tag, ".cmd_size"}, 32'(o.cmd_size), 32'(isz));
      chk({tag, ".dbus_din"}, o.din, e.din);
      chk({tag, ".cmd_stable"}, 32'(o.cmd_stable), 32'd1);
      chk({tag, ".dbus_ready_in_wait"}, 32'(o.wait_rdy), 32'd1);
    end
    chk({tag, ".no_spurious_in_ready"}, 32'(o.no_spur), 32'd1);
    chk({tag, ".dout"}, o.dout, e.dout);
    chk({tag, ".tlb_miss"}, 32'(o.tlb), 32'(e.tlb));
    chk({tag, ".page_fault"}, 32'(o.pf), 32'(e.pf));
    chk({tag, ".misalign"}, 32'(o.mis), 32'(e.mis));
    chk({tag, ".vaddr"}, o.vaddr, ia);
    chk({tag, ".outputs_held"}, 32'(o.held), 32'd1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t vt[10];
  obs_t o;
  exp_t e;

  initial begin
    vt[0] = '{1, 0, 3'd3, 32'h1000, 32'hDEAD_BEEF, 32'h0, 0, 0, 1, 0, 0, 0, 0,
              32'h1000, 32'hDEAD_BEEF, 32'h0, 0, 0};
    vt[1] = '{0, 1, 3'd1, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0, 1, 0, 0, 0, 0,
              32'h1003, 32'h0, 32'hFFFF_FF80, 0, 0};
    vt[2] = '{0, 0, 3'd1, 32'h1003, 32'h0, 32'h80FF_1234, 0, 0, 1, 0, 0, 0, 0,
              32'h1003, 32'h0, 32'h0000_0080, 0, 0};
    vt[3] = '{1, 0, 3'd2, 32'h1002, 32'h1234_ABCD, 32'h0, 0, 0, 1, 5, 0, 3, 0,
              32'h1002, 32'hABCD_ABCD, 32'h0, 0, 0};
    vt[4] = '{0, 0, 3'd3, 32'h3000, 32'h0, 32'h1234_5678, 1, 0, 1, 0, 1, 0, 0,
              32'h3000, 32'h0, 32'h0, 1, 0};
    vt[5] = '{0, 1, 3'd2, 32'h4002, 32'h0, 32'h8001_7FFF, 0, 0, 1, 0, 0, 0, 0,
              32'h4002, 32'h0, 32'hFFFF_8001, 0, 0};
    vt[6] = '{0, 1, 3'd2, 32'h4000, 32'h0, 32'h8001_7FFF, 0, 0, 1, 1, 0, 1, 0,
              32'h4000, 32'h0, 32'h0000_7FFF, 0, 0};
    vt[7] = '{1, 0, 3'd1, 32'h5001, 32'h1234_56A5, 32'h0, 0, 1, 0, 0, 0, 0, 0,
              32'h5001, 32'hA5A5_A5A5, 32'h0, 0, 1};
    vt[8] = '{0, 0, 3'd1, 32'h6001, 32'h0, 32'h1122_3344, 0, 0, 1, 2, 0, 0, 1,
              32'h6001, 32'h0, 32'h0000_0033, 0, 0};
    vt[9] = '{0, 1, 3'd3, 32'h7000, 32'h0, 32'hCAFE_F00D, 0, 0, 1, 0, 2, 0, 0,
              32'h7000, 32'h0, 32'hCAFE_F00D, 0, 0};

    rst = 1; in_valid = 0; we = 0; sext = 0; size = 0; addr = 0; wdat = 0; out_ready = 0;
    dbus_if.cmd_ready = 0; dbus_if.valid = 0; dbus_if.dout = 0;
    dbus_if.exp_tlb_miss = 0; dbus_if.exp_page_fault = 0;
    step(); step();
    chk("reset.in_ready", 32'(in_ready), 32'd1);
    chk("reset.out_valid", 32'(out_valid), 32'd0);
    chk("reset.cmd_valid", 32'(dbus_if.cmd_valid), 32'd0);
    chk("reset.dbus_ready", 32'(dbus_if.ready), 32'd0);
    chk("reset.dout", dout, 32'd0);
    chk("reset.flags", {29'd0, tlb_o, pf_o, mis_o}, 32'd0);
    chk("reset.vaddr", vaddr, 32'd0);
    chk("reset.cmd_addr", dbus_if.cmd_addr, 32'd0);
    chk("reset.din", dbus_if.din, 32'd0);
    chk("reset.cmd_we_size", {28'd0, dbus_if.cmd_we, dbus_if.cmd_size}, 32'd0);
    rst = 0;
    step();

    for (int i = 0; i < 10; i++) begin
      do_op(vt[i].we, vt[i].sext, vt[i].size, vt[i].addr, vt[i].wdat, vt[i].rdat,
            vt[i].tlb, vt[i].pf, vt[i].rv, vt[i].cw, vt[i].rw, vt[i].ow, vt[i].noise, o);
      e.cmd = 1; e.cmd_addr = vt[i].e_cmd_addr; e.din = vt[i].e_din; e.dout = vt[i].e_dout;
      e.tlb = vt[i].e_tlb; e.pf = vt[i].e_pf; e.mis = 0; e.lat = 3 + vt[i].cw + vt[i].rw;
      compare($sformatf("vec%0d", i), e, o, vt[i].we, vt[i].size, vt[i].addr);
    end

    // Misaligned half load.
    do_op(0, 0, 3'd2, 32'h2001, 32'h0, 32'hAAAA_5555, 0, 0, 1, 0, 0, 0, 0, o);
    e = model(0, 0, 3'd2, 32'h2001, 32'h0, 32'hAAAA_5555, 0, 0, 0, 0);
    compare("misalign_half", e, o, 0, 3'd2, 32'h2001);
`ifdef NCPU_LSU_MISALIGN_EXP_EN
    chk("misalign_half.flag", 32'(o.mis), 32'd1);
    chk("misalign_half.no_cmd", 32'(o.saw_cmd), 32'd0);
`else
    chk("misalign_half.cmd_addr_forced", o.cmd_addr, 32'h2000);
    chk("misalign_half.flag_tied0", 32'(o.mis), 32'd0);
`endif

    // Reset while waiting for the dbus response; a late response must be ignored.
    in_valid = 1; we = 0; sext = 0; size = 3'd3; addr = 32'h8000; wdat = 0;
    step();
    in_valid = 0;
    dbus_if.cmd_ready = 1;
    step();
    dbus_if.cmd_ready = 0;
    chk("rst_wait.dbus_ready_before", 32'(dbus_if.ready), 32'd1);
    rst = 1;
    step();
    rst = 0;
    chk("rst_wait.in_ready", 32'(in_ready), 32'd1);
    chk("rst_wait.dbus_ready", 32'(dbus_if.ready), 32'd0);
    chk("rst_wait.cmd_valid", 32'(dbus_if.cmd_valid), 32'd0);
    dbus_if.valid = 1; dbus_if.dout = 32'h1234_5678;
    step();
    dbus_if.valid = 0;
    begin
      bit late_ok;
      late_ok = 1;
      for (int k = 0; k < 3; k++) begin
        if (out_valid || !in_ready) late_ok = 0;
        step();
      end
      chk("rst_wait.late_dbus_valid_ignored", 32'(late_ok), 32'd1);
    end

    // Reset while the command is stalled.
    in_valid = 1; we = 1; size = 3'd3; addr = 32'h9000; wdat = 32'h5A5A_5A5A;
    step();
    in_valid = 0;
    chk("rst_cmd.cmd_valid_before", 32'(dbus_if.cmd_valid), 32'd1);
    rst = 1;
    step();
    rst = 0;
    chk("rst_cmd.cmd_valid_after", 32'(dbus_if.cmd_valid), 32'd0);
    chk("rst_cmd.in_ready_after", 32'(in_ready), 32'd1);

    for (int i = 0; i < 60; i++) begin
      bit          rwe, rsx, rtlb, rpf, rrv, rnz;
      logic [2:0]  rsz;
      logic [31:0] ra, rwd, rrd;
      int          rcw, rrw, row;
      rwe = 1'($urandom_range(0, 1)); rsx = 1'($urandom_range(0, 1));
      rsz = 3'($urandom_range(0, 7)); ra = $urandom; rwd = $urandom; rrd = $urandom;
      rtlb = ($urandom_range(0, 7) == 0); rpf = ($urandom_range(0, 7) == 0);
      rrv = (rtlb || rpf) ? 1'($urandom_range(0, 1)) : 1'b1;
      rcw = $urandom_range(0, 3); rrw = $urandom_range(0, 3); row = $urandom_range(0, 3);
      rnz = 1'($urandom_range(0, 1));
      do_op(rwe, rsx, rsz, ra, rwd, rrd, rtlb, rpf, rrv, rcw, rrw, row, rnz, o);
      e = model(rwe, rsx, rsz, ra, rwd, rrd, rtlb, rpf, rcw, rrw);
      compare($sformatf("rand%0d", i), e, o, rwe, rsz, ra);
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
